// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the AXIS audio mute stage.
//   GAIN_UNITY   - Q1.15 gain value meaning exactly 1.0 (passthrough)
//   SAMPLE_W     - width of the signed audio sample in each beat
//   TAG_W        - width of the opaque tag carried above the sample
//   gain_t       - unsigned 16-bit gain, range 0..GAIN_UNITY
//   mute_state_e - mute controller states
package audio_pkg;

  localparam int GAIN_UNITY = 32768;
  localparam int SAMPLE_W   = 24;
  localparam int TAG_W      = 8;

  typedef logic [15:0] gain_t;

  typedef enum logic [1:0] {
    UNMUTED   = 2'd0,
    RAMP_DOWN = 2'd1,
    MUTED     = 2'd2,
    RAMP_UP   = 2'd3
  } mute_state_e;

endpackage

// File: rtl/mute_gain_ctrl.sv
// mute_gain_ctrl: mute state machine with a saturating linear gain ramp.
// The gain moves by RAMP_STEP once per frame boundary, towards 0 while mute
// is requested and towards unity otherwise; nothing changes between
// boundaries.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   boundary_i  - one-cycle strobe: last beat of a frame accepted this cycle
//   mute_i      - mute request, only looked at when boundary_i is high
//   gain_o      - current Q1.15 gain (0..32768)
//   muted_o     - registered, high in MUTED
//   ramping_o   - registered, high in RAMP_DOWN or RAMP_UP
module mute_gain_ctrl
  import audio_pkg::*;
#(
  parameter int RAMP_STEP   = 64,
  parameter bit START_MUTED = 1'b1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  boundary_i,
  input  logic  mute_i,
  output gain_t gain_o,
  output logic  muted_o,
  output logic  ramping_o
);

  localparam logic [16:0] STEP_W  = 17'(RAMP_STEP);
  localparam logic [16:0] UNITY_W = 17'(GAIN_UNITY);
  localparam gain_t       RESET_GAIN  = START_MUTED ? gain_t'(0) : gain_t'(GAIN_UNITY);
  localparam mute_state_e RESET_STATE = START_MUTED ? MUTED : UNMUTED;

  mute_state_e state_q, state_d;
  gain_t       gain_q;
  logic        muted_q, ramping_q;

  // 17-bit intermediates so that unity + step cannot wrap
  logic [16:0] gain_ext, gain_sum, gain_up, gain_dn, gain_nx;
  logic        step_up, step_dn;

  always_comb begin
    gain_ext = {1'b0, gain_q};
    gain_sum = gain_ext + STEP_W;
    gain_up  = (gain_sum > UNITY_W) ? UNITY_W : gain_sum;
    gain_dn  = (gain_ext > STEP_W) ? (gain_ext - STEP_W) : 17'd0;

    step_up = 1'b0;
    step_dn = 1'b0;
    case (state_q)
      UNMUTED: step_dn = mute_i;
      MUTED:   step_up = !mute_i;
      // mid-ramp the direction simply follows mute, so reversal is seamless
      default: begin
        step_dn = mute_i;
        step_up = !mute_i;
      end
    endcase

    gain_nx = gain_ext;
    state_d = state_q;
    if (step_dn) begin
      gain_nx = gain_dn;
      state_d = (gain_dn == 17'd0) ? MUTED : RAMP_DOWN;
    end else if (step_up) begin
      gain_nx = gain_up;
      state_d = (gain_up == UNITY_W) ? UNMUTED : RAMP_UP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      gain_q    <= RESET_GAIN;
      muted_q   <= START_MUTED;
      ramping_q <= 1'b0;
    end else if (boundary_i) begin
      state_q   <= state_d;
      gain_q    <= gain_t'(gain_nx);
      muted_q   <= (state_d == MUTED);
      ramping_q <= (state_d == RAMP_DOWN) || (state_d == RAMP_UP);
    end
  end

  assign gain_o    = gain_q;
  assign muted_o   = muted_q;
  assign ramping_o = ramping_q;

endmodule

// File: rtl/axis_soft_mute.sv
// axis_soft_mute: click-free AXI-Stream mute stage.
// Each beat holds a signed 24-bit sample in [23:0] and a tag in [31:24].
// The sample is scaled by a Q1.15 gain that ramps per frame between 0 and
// unity; the tag and tlast pass through untouched. One output register,
// one cycle latency, full throughput.
// Ports:
//   clk, reset               - clock and synchronous active-high reset
//   mute                     - mute request, sampled at frame boundaries
//   s_axis_data/valid/last   - input stream, s_axis_ready back-pressure
//   m_axis_data/valid/last   - output stream, m_axis_ready from downstream
//   muted, ramping           - status from the gain controller
module axis_soft_mute
  import audio_pkg::*;
#(
  parameter int RAMP_STEP   = 64,
  parameter bit START_MUTED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mute,
  input  logic [31:0] s_axis_data,
  input  logic        s_axis_valid,
  output logic        s_axis_ready,
  input  logic        s_axis_last,
  output logic [31:0] m_axis_data,
  output logic        m_axis_valid,
  input  logic        m_axis_ready,
  output logic        m_axis_last,
  output logic        muted,
  output logic        ramping
);

  logic [31:0] m_data_q;
  logic        m_valid_q, m_last_q;
  logic        accept, boundary;
  gain_t       gain;

  logic signed [SAMPLE_W-1:0] sample_s;
  logic signed [16:0]         gain_s;
  logic signed [40:0]         prod;
  logic        [SAMPLE_W-1:0] scaled;

  assign s_axis_ready = !reset && (!m_valid_q || m_axis_ready);
  assign accept       = s_axis_valid && s_axis_ready;
  // gain only moves after the last beat of a frame, so L and R share a gain
  assign boundary     = accept && s_axis_last;

  mute_gain_ctrl #(
    .RAMP_STEP  (RAMP_STEP),
    .START_MUTED(START_MUTED)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .boundary_i(boundary),
    .mute_i    (mute),
    .gain_o    (gain),
    .muted_o   (muted),
    .ramping_o (ramping)
  );

  // Signed multiply with the gain zero-extended so 32768 stays positive;
  // the arithmetic shift floors, and unity gain reproduces the sample exactly.
  assign sample_s = s_axis_data[SAMPLE_W-1:0];
  assign gain_s   = {1'b0, gain};
  assign prod     = sample_s * gain_s;
  assign scaled   = SAMPLE_W'(prod >>> 15);

  always_ff @(posedge clk) begin
    if (reset) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (accept) begin
      m_data_q  <= {s_axis_data[SAMPLE_W +: TAG_W], scaled};
      m_valid_q <= 1'b1;
      m_last_q  <= s_axis_last;
    end else if (m_valid_q && m_axis_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_axis_data  = m_data_q;
  assign m_axis_valid = m_valid_q;
  assign m_axis_last  = m_last_q;

endmodule

// File: tb/tb_axis_soft_mute.sv
// tb_axis_soft_mute: randomized scoreboard bench for axis_soft_mute.
// A reference model tracks the gain as a plain integer (one ramp step per
// accepted frame end, clamped to 0..32768) and pushes the expected output of
// every accepted beat into a queue; an independent monitor pops and compares
// whenever the DUT hands a beat downstream.
module tb_axis_soft_mute;

  localparam int STEP    = 12000;  // not a divisor of 32768, so clamping is exercised
  localparam bit START_M = 1'b0;
  localparam int UNITY   = 32768;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mute = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic        muted, ramping;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;
  beat_t exp_q[$];

  int g = 0;
  bit primed = 1'b0;
  bit rst_chk = 1'b0;

  axis_soft_mute #(
    .RAMP_STEP  (STEP),
    .START_MUTED(START_M)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mute        (mute),
    .s_axis_data (s_data),
    .s_axis_valid(s_valid),
    .s_axis_ready(s_ready),
    .s_axis_last (s_last),
    .m_axis_data (m_data),
    .m_axis_valid(m_valid),
    .m_axis_ready(m_ready),
    .m_axis_last (m_last),
    .muted       (muted),
    .ramping     (ramping)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] expected_beat(logic [31:0] d, int gain);
    logic signed [23:0] smp;
    longint p;
    smp = d[23:0];
    p = longint'(smp) * longint'(gain);
    p = p >>> 15;  // floor division by 2^15
    return {d[31:24], p[23:0]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: decides what the coming edge does, before it happens.
  always @(negedge clk) begin
    if (primed) begin
      check("muted", {31'b0, muted}, {31'b0, g == 0});
      check("ramping", {31'b0, ramping}, {31'b0, (g > 0) && (g < UNITY)});
      check("s_ready", {31'b0, s_ready}, {31'b0, !reset && (!m_valid || m_ready)});
    end
    if (reset) begin
      exp_q.delete();
      g = START_M ? 0 : UNITY;
      primed = 1'b1;
    end else if (s_valid && s_ready) begin
      exp_q.push_back('{expected_beat(s_data, g), s_last});
      if (s_last) begin
        if (mute) g = (g > STEP) ? g - STEP : 0;
        else      g = (g + STEP > UNITY) ? UNITY : g + STEP;
      end
    end
  end

  // Monitor: compares what the DUT presents against the queue head.
  always @(negedge clk) begin
    beat_t e;
    if (rst_chk) begin
      check("rst_valid", {31'b0, m_valid}, 32'd0);
      check("rst_data", m_data, 32'd0);
      check("rst_last", {31'b0, m_last}, 32'd0);
      rst_chk = 1'b0;
    end
    if (reset) begin
      rst_chk = 1'b1;
    end else if (m_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none", m_data);
      end else if (m_ready) begin
        e = exp_q.pop_front();
        beats++;
        $display("beat %0d data %h last %0b", beats, m_data, m_last);
        check("data", m_data, e.data);
        check("last", {31'b0, m_last}, {31'b0, e.last});
      end else begin
        check("hold_data", m_data, exp_q[0].data);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  task automatic send_beat(logic [31:0] d, logic last);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    s_data = d;
    s_last = last;
    s_valid = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic send_frame(logic [31:0] l, logic [31:0] r);
    send_beat(l, 1'b0);
    send_beat(r, 1'b1);
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    wait_cycles(3);
    reset = 1'b0;

    // unity passthrough, including full-scale extremes
    for (int i = 0; i < 4; i++) send_frame({8'hA5, 24'h123456}, {8'hA5, 24'h800000});
    send_frame({8'h3C, 24'h7FFFFF}, {8'hC3, 24'h800000});

    // ramp all the way down, then some frames while muted
    mute = 1'b1;
    for (int i = 0; i < 5; i++) send_frame({8'h11, 24'h400000}, {8'h22, 24'hC00000});
    check("muted_after_ramp", {31'b0, muted}, 32'd1);

    // partial ramp up, reversal, then up to unity with clamp
    mute = 1'b0;
    for (int i = 0; i < 2; i++) send_frame({8'h33, 24'h400000}, {8'h44, 24'h400000});
    mute = 1'b1;
    send_frame({8'h55, 24'h400000}, {8'h66, 24'h400000});
    mute = 1'b0;
    for (int i = 0; i < 3; i++) send_frame({8'h77, 24'h7FFFFF}, {8'h88, 24'h800000});

    // random traffic, random back-pressure, mute toggling anywhere
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) mute = ~mute;
      send_beat($urandom, 1'b0);
      if ($urandom_range(0, 3) == 0) mute = ~mute;
      if ($urandom_range(0, 4) == 0) wait_cycles($urandom_range(1, 3));
      send_beat($urandom, 1'b1);
    end

    // directed stall of five cycles in the middle of a frame
    ready_mode = 0;
    mute = 1'b1;
    wait_cycles(2);
    ready_mode = 2;
    wait_cycles(2);
    send_beat({8'h99, 24'h2468AC}, 1'b0);
    s_data = {8'h9A, 24'hDCBA98};
    s_last = 1'b1;
    s_valid = 1'b1;
    @(negedge clk);
    held = m_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ready", {31'b0, s_ready}, 32'd0);
      check("stall_valid", {31'b0, m_valid}, 32'd1);
      check("stall_data", m_data, held);
    end
    @(posedge clk);
    #1;
    ready_mode = 0;
    send_beat({8'h9A, 24'hDCBA98}, 1'b1);

    // reach unity, start a ramp, then reset with a beat held
    mute = 1'b0;
    for (int i = 0; i < 4; i++) send_frame($urandom, $urandom);
    mute = 1'b1;
    send_frame($urandom, $urandom);
    ready_mode = 2;
    wait_cycles(3);
    send_beat({8'hEE, 24'h0F0F0F}, 1'b0);
    @(negedge clk);
    check("pre_reset_valid", {31'b0, m_valid}, 32'd1);
    check("pre_reset_ramping", {31'b0, ramping}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_valid", {31'b0, m_valid}, 32'd0);
    check("post_reset_muted", {31'b0, muted}, 32'd0);
    check("post_reset_ramping", {31'b0, ramping}, 32'd0);
    @(posedge clk);
    #1;
    ready_mode = 0;
    send_frame({8'h5A, 24'h7FFFFF}, {8'hA5, 24'h800000});

    // drain and confirm nothing was lost
    mute = 1'b0;
    wait_cycles(10);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_soft_mute.md
Name: axis_soft_mute

Overview:
- Click-free mute stage that sits directly downstream of the ring modulator in the AXIS audio chain.
- Each 32-bit beat carries a signed 24-bit sample in [23:0] and an 8-bit tag in [31:24]; tlast marks the last beat of a frame (stereo pair).
- The sample is scaled by a Q1.15 gain. The gain ramps linearly between 0 and unity at frame boundaries whenever the mute control changes.

Parameters:
- RAMP_STEP, 64: gain increment/decrement per frame, Q1.15. 64 gives 512 frames for a full ramp (~10.7 ms at 48 kHz). Legal range 1..32768.
- START_MUTED, 1: 1 = reset into MUTED with gain 0; 0 = reset into UNMUTED with gain 32768.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- mute, in, 1: mute request, level-sensitive, sampled only at frame boundaries.
- s_axis_data, in, 32: input beat; [23:0] is the signed sample, [31:24] is the tag.
- s_axis_valid, in, 1: input valid.
- s_axis_ready, out, 1: input ready.
- s_axis_last, in, 1: last beat of frame.
- m_axis_data, out, 32: output beat.
- m_axis_valid, out, 1: output valid.
- m_axis_ready, in, 1: downstream ready.
- m_axis_last, out, 1: forwarded s_axis_last.
- muted, out, 1: high in state MUTED.
- ramping, out, 1: high in RAMP_DOWN or RAMP_UP.

Behaviour:
- Reset (clk edge with reset=1):
  - m_axis_valid=0, m_axis_data=0, m_axis_last=0.
  - gain and state per START_MUTED.
  - muted and ramping reflect the reset state on the cycle after reset.
  - Reset mid-ramp or mid-frame drops any held output beat and restores the START_MUTED state. No partial ramp is retained.
- Handshake:
  - Single output register; s_axis_ready = !reset && (!m_axis_valid || m_axis_ready). This gives full throughput.
  - Accept = s_axis_valid && s_axis_ready. On accept the output register loads the processed beat and m_axis_valid=1, so latency is 1 cycle.
  - If m_axis_valid && m_axis_ready and there is no accept, m_axis_valid goes to 0.
  - While m_axis_valid=1 and m_axis_ready=0, m_axis_data and m_axis_last hold stable.
- Arithmetic:
  - prod = signed sample (24b) times signed {1'b0, gain} (17b), giving a 41b result. out = prod >>> 15, truncated to [23:0] (arithmetic shift, floor).
  - gain=32768 is exact passthrough; gain=0 gives 0.
  - The tag [31:24] is passed unchanged; last is forwarded.
- Gain timing:
  - Every beat uses the gain value current at its accept cycle.
  - Gain and state update only on a frame boundary, i.e. an accept with s_axis_last=1, taking effect from the next beat. Both beats of a frame therefore always share one gain.
- States:
  - UNMUTED (gain=32768): mute=1 at boundary -> RAMP_DOWN, and gain -= RAMP_STEP in the same boundary.
  - RAMP_DOWN: mute=1 -> gain = max(gain-RAMP_STEP, 0). On reaching 0 -> MUTED. If mute=0 -> RAMP_UP with gain = min(gain+RAMP_STEP, 32768). Reversal happens mid-ramp with no jump.
  - MUTED (gain=0): mute=0 at boundary -> RAMP_UP, with gain += RAMP_STEP.
  - RAMP_UP: mute=0 -> gain = min(gain+RAMP_STEP, 32768). On reaching 32768 -> UNMUTED. If mute=1 -> RAMP_DOWN with a step down.
  - Saturating add/sub must not wrap; use a 17-bit intermediate.
- Stream stall: with no accepts, gain and state freeze. A change of mute with no frames flowing has no effect until the next boundary.
- The mute value is sampled only in the boundary cycle; toggles between boundaries are ignored.

Decomposition:
- Package audio_pkg: GAIN_UNITY=32768, SAMPLE_W=24, TAG_W=8, gain typedef (16b unsigned), and the state enum {UNMUTED, RAMP_DOWN, MUTED, RAMP_UP}.
- Optional sub-module mute_gain_ctrl: state machine plus saturating gain register, inputs boundary/mute, outputs gain/muted/ramping.
- The datapath (multiply plus output register) stays in the top module.

Test Plan:
- Unmuted reset (START_MUTED=0, RAMP_STEP=64), mute=0, stream 4 frames with samples 0x123456 and 0x800000, tag 0xA5 -> outputs identical to inputs with 1-cycle latency; muted=0, ramping=0.
- Mute ramp (START_MUTED=0, RAMP_STEP=8192): assert mute, stream frames of sample 0x400000 (L and R) -> per-frame outputs 0x400000, 0x300000, 0x200000, 0x100000, then 0. muted=1 after the 4th boundary; ramping=1 during.
- Reversal: in RAMP_DOWN at gain 16384 (sample 0x400000 outputs 0x200000), deassert mute -> next frame 0x300000, then 0x400000. State reaches UNMUTED with no jump.
- Backpressure: hold m_axis_ready=0 for 5 cycles mid-frame -> s_axis_ready=0, output beat stable, gain unchanged until the boundary beat is accepted. No beat is lost or duplicated.
- Saturation: RAMP_STEP=30000 from MUTED -> gain 30000, then 32768, never wrapping. Sample 0x7FFFFF at gain 32768 outputs 0x7FFFFF; sample 0x800000 outputs 0x800000.
- Reset mid-ramp, with m_axis_valid=1 -> next cycle m_axis_valid=0, and state/gain return to the START_MUTED values.
